// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: FSM encoding and instruction field layout.
package sc_fetch_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      FETCH = 3'd2,
      HOLD  = 3'd3,
      FAULT = 3'd4
   } state_t;

   localparam int unsigned OPC_HI = 15;
   localparam int unsigned OPC_LO = 9;
   localparam int unsigned DR_HI  = 8;
   localparam int unsigned DR_LO  = 6;
   localparam int unsigned SA_HI  = 5;
   localparam int unsigned SA_LO  = 3;
   localparam int unsigned SB_HI  = 2;
   localparam int unsigned SB_LO  = 0;

   localparam int unsigned OFFSET_W = 6;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: PC input, instruction-memory req/ack, decode valid/ready and PC-controller feedback.
interface instruction_fetch_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16
) ();

   logic [ADDR_W-1:0] PC;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;
   logic [DATA_W-1:0] IR;
   logic              ir_valid;
   logic              ir_ready;
   logic              pc_advance;
   logic [ADDR_W-1:0] branch_offset;
   logic              fetch_fault;

   modport master (
      input  PC, mem_ack, mem_rdata, ir_ready,
      output mem_req, mem_addr, IR, ir_valid, pc_advance, branch_offset, fetch_fault
   );

   modport slave (
      output PC, mem_ack, mem_rdata, ir_ready,
      input  mem_req, mem_addr, IR, ir_valid, pc_advance, branch_offset, fetch_fault
   );

endinterface

// File: rtl/instruction_fetch_offset_sign_ext.sv
// Sign-extends the 6-bit branch offset field to the address width.
module offset_sign_ext
   import sc_fetch_pkg::*;
#(
   parameter int unsigned ADDR_W = 16
) (
   input  logic [OFFSET_W-1:0] i_offset,
   output logic [ADDR_W-1:0]   o_ext
);

   assign o_ext = {{(ADDR_W-OFFSET_W){i_offset[OFFSET_W-1]}}, i_offset};

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: latches PC, reads instruction memory with a bounded wait,
// holds the word in IR for decode and pulses pc_advance on acceptance.
module instruction_fetch
   import sc_fetch_pkg::*;
#(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned TIMEOUT = 8
) (
   input  logic         clock,
   input  logic         reset,
   instruction_fetch_if.master bus
);

   localparam int unsigned      CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t              r_state;
   state_t              w_next;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_ir;
   logic                r_ir_valid;
   logic                r_fault;
   logic [CNT_W-1:0]    r_wait_cnt;
   logic                w_mem_req;
   logic                w_pc_advance;
   logic                w_addr_load;
   logic                w_ir_load;
   logic                w_cnt_inc;
   logic [OFFSET_W-1:0] w_offset;

   always_ff @(posedge clock) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next       = r_state;
      w_mem_req    = 1'b0;
      w_pc_advance = 1'b0;
      w_addr_load  = 1'b0;
      w_ir_load    = 1'b0;
      w_cnt_inc    = 1'b0;
      case (r_state)
         IDLE:  w_next = ISSUE;
         ISSUE: begin
            w_addr_load = 1'b1;
            w_next      = FETCH;
         end
         FETCH: begin
            w_mem_req = 1'b1;
            if (bus.mem_ack) begin
               w_ir_load = 1'b1;
               w_next    = HOLD;
            end else if ((TIMEOUT != 0) && (r_wait_cnt == CNT_LAST)) begin
               w_next = FAULT;
            end else begin
               w_cnt_inc = 1'b1;
            end
         end
         HOLD: begin
            if (bus.ir_ready) begin
               w_pc_advance = 1'b1;
               w_next       = ISSUE;
            end
         end
         FAULT:   w_next = FAULT;
         default: w_next = IDLE;
      endcase
   end

   // The wait counter is cleared while the address is latched so every request starts a fresh window.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_mem_addr <= '0;
         r_ir       <= '0;
         r_ir_valid <= 1'b0;
         r_fault    <= 1'b0;
         r_wait_cnt <= '0;
      end else begin
         if (w_addr_load) begin
            r_mem_addr <= bus.PC;
            r_wait_cnt <= '0;
         end
         if (w_cnt_inc) r_wait_cnt <= r_wait_cnt + 1'b1;
         if (w_ir_load) begin
            r_ir       <= bus.mem_rdata;
            r_ir_valid <= 1'b1;
         end
         if (w_pc_advance) r_ir_valid <= 1'b0;
         if (w_next == FAULT) r_fault <= 1'b1;
      end
   end

   assign w_offset = {r_ir[DR_HI:DR_LO], r_ir[SB_HI:SB_LO]};

   offset_sign_ext #(.ADDR_W(ADDR_W)) u_offset_sign_ext (
      .i_offset (w_offset),
      .o_ext    (bus.branch_offset)
   );

   assign bus.mem_req     = w_mem_req;
   assign bus.mem_addr    = r_mem_addr;
   assign bus.IR          = r_ir;
   assign bus.ir_valid    = r_ir_valid;
   assign bus.pc_advance  = w_pc_advance;
   assign bus.fetch_fault = r_fault;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: vector table for IR/branch_offset plus multi-cycle sequences.
module tb_instruction_fetch;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   instruction_fetch_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   instruction_fetch #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(8)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;

   logic        prev_req = 1'b0;
   logic [15:0] addr_q[$];
   int unsigned adv_cnt = 0;

   always @(posedge clk) begin
      if (bus.mem_req && !prev_req) addr_q.push_back(bus.mem_addr);
      prev_req <= bus.mem_req;
      if (bus.pc_advance) adv_cnt <= adv_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic [15:0] rdata;
      int unsigned lat;
      logic [15:0] exp_off;
   } vec_t;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic do_reset(input int unsigned n);
      rst = 1'b1;
      repeat (n) step();
      rst = 1'b0;
   endtask

   task automatic wait_req(input int unsigned max);
      int unsigned i = 0;
      while (!bus.mem_req && i < max) begin
         step();
         i++;
      end
      chk("req_seen", 32'(bus.mem_req), 32'd1);
   endtask

   task automatic fetch_word(input logic [15:0] d, input int unsigned lat);
      wait_req(6);
      repeat (lat) step();
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = d;
      step();
      bus.mem_ack   = 1'b0;
   endtask

   initial begin
      vec_t        vec[7];
      int unsigned base_q;
      int unsigned base_adv;
      int unsigned cnt;
      logic [15:0] pc;

      vec[0] = '{16'h1234, 0, 16'h0004};
      vec[1] = '{16'h01C5, 1, 16'hFFFD};
      vec[2] = '{16'h00C2, 2, 16'h001A};
      vec[3] = '{16'h0000, 0, 16'h0000};
      vec[4] = '{16'h01FF, 3, 16'hFFFF};
      vec[5] = '{16'h0100, 4, 16'hFFE0};
      vec[6] = '{16'hFEC7, 1, 16'h001F};

      bus.PC        = 16'h0000;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 16'h0000;
      bus.ir_ready  = 1'b0;

      // Reset values
      do_reset(3);
      rst = 1'b1;
      #1;
      chk("rst_mem_req",  32'(bus.mem_req), 32'd0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("rst_ir",       32'(bus.IR), 32'd0);
      chk("rst_ir_valid", 32'(bus.ir_valid), 32'd0);
      chk("rst_fault",    32'(bus.fetch_fault), 32'd0);
      chk("rst_pc_adv",   32'(bus.pc_advance), 32'd0);
      chk("rst_offset",   32'(bus.branch_offset), 32'd0);

      // First fetch: mem_req at cycle 2, zero-wait ack, IR valid at cycle 3
      rst = 1'b0;
      step();
      chk("c1_mem_req", 32'(bus.mem_req), 32'd0);
      step();
      chk("c2_mem_req", 32'(bus.mem_req), 32'd1);
      chk("c2_mem_addr", 32'(bus.mem_addr), 32'h0000);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 16'h1234;
      step();
      bus.mem_ack = 1'b0;
      chk("c3_ir_valid", 32'(bus.ir_valid), 32'd1);
      chk("c3_ir", 32'(bus.IR), 32'h1234);
      bus.ir_ready = 1'b1;
      #1;
      chk("c3_pc_adv", 32'(bus.pc_advance), 32'd1);
      step();
      bus.ir_ready = 1'b0;
      chk("c4_ir_valid", 32'(bus.ir_valid), 32'd0);
      chk("c4_pc_adv", 32'(bus.pc_advance), 32'd0);

      // Table: IR capture and branch_offset decode
      for (int i = 0; i < 7; i++) begin
         fetch_word(vec[i].rdata, vec[i].lat);
         chk("tbl_ir", 32'(bus.IR), 32'(vec[i].rdata));
         chk("tbl_ir_valid", 32'(bus.ir_valid), 32'd1);
         chk("tbl_offset", 32'(bus.branch_offset), 32'(vec[i].exp_off));
         chk("tbl_pc_adv_lo", 32'(bus.pc_advance), 32'd0);
         bus.ir_ready = 1'b1;
         #1;
         chk("tbl_pc_adv_hi", 32'(bus.pc_advance), 32'd1);
         step();
         bus.ir_ready = 1'b0;
         chk("tbl_ir_valid_clr", 32'(bus.ir_valid), 32'd0);
      end

      // Back-to-back accepts with PC stepping, 3-cycle ack latency
      pc = 16'h0000;
      bus.PC = pc;
      do_reset(2);
      bus.ir_ready = 1'b1;
      base_q   = addr_q.size();
      base_adv = adv_cnt;
      for (int k = 0; k < 3; k++) begin
         fetch_word(16'h1000 + 16'(k), 3);
         chk("seq_mem_addr", 32'(bus.mem_addr), 32'(k));
         chk("seq_ir", 32'(bus.IR), 32'h1000 + 32'(k));
         chk("seq_pc_adv", 32'(bus.pc_advance), 32'd1);
         step();
         pc = pc + 16'd1;
         bus.PC = pc;
         chk("seq_req_k1", 32'(bus.mem_req), 32'd0);
         chk("seq_pc_adv_once", 32'(bus.pc_advance), 32'd0);
         if (k < 2) begin
            step();
            chk("seq_req_k2", 32'(bus.mem_req), 32'd1);
         end
      end
      chk("seq_fetch_count", addr_q.size() - base_q, 32'd3);
      chk("seq_adv_count", adv_cnt - base_adv, 32'd3);
      for (int k = 0; k < 3; k++) begin
         if (base_q + k < addr_q.size())
            chk("seq_addr_order", 32'(addr_q[base_q + k]), 32'(k));
         else
            chk("seq_addr_missing", 32'd0, 32'd1);
      end
      bus.ir_ready = 1'b0;

      // Decode stalls 5 cycles; spurious ack must not touch IR
      fetch_word(16'h5A5A, 1);
      for (int c = 0; c < 5; c++) begin
         chk("stall_ir", 32'(bus.IR), 32'h5A5A);
         chk("stall_ir_valid", 32'(bus.ir_valid), 32'd1);
         chk("stall_pc_adv", 32'(bus.pc_advance), 32'd0);
         chk("stall_mem_req", 32'(bus.mem_req), 32'd0);
         if (c == 2) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 16'hBEEF;
         end
         step();
         bus.mem_ack = 1'b0;
      end
      chk("stall_ir_after", 32'(bus.IR), 32'h5A5A);
      bus.ir_ready = 1'b1;
      step();
      bus.ir_ready = 1'b0;

      // Timeout: no ack, 8 request cycles then sticky fault
      bus.PC = 16'h0040;
      do_reset(2);
      wait_req(4);
      cnt = 0;
      while (bus.mem_req && cnt < 20) begin
         cnt++;
         step();
      end
      chk("to_req_cycles", cnt, 32'd8);
      chk("to_fault", 32'(bus.fetch_fault), 32'd1);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 16'hDEAD;
      repeat (3) step();
      bus.mem_ack = 1'b0;
      chk("to_fault_sticky", 32'(bus.fetch_fault), 32'd1);
      chk("to_mem_req", 32'(bus.mem_req), 32'd0);
      chk("to_ir_valid", 32'(bus.ir_valid), 32'd0);
      chk("to_ir", 32'(bus.IR), 32'h0000);
      bus.PC = 16'h0077;
      do_reset(1);
      chk("to_fault_clr", 32'(bus.fetch_fault), 32'd0);
      wait_req(4);
      chk("to_restart_addr", 32'(bus.mem_addr), 32'h0077);

      // PC change during FETCH, then reset in FETCH coinciding with an ack
      bus.PC = 16'h0123;
      do_reset(2);
      wait_req(4);
      chk("hold_addr_a", 32'(bus.mem_addr), 32'h0123);
      bus.PC = 16'h9999;
      step();
      chk("hold_addr_b", 32'(bus.mem_addr), 32'h0123);
      rst           = 1'b1;
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 16'hABCD;
      step();
      chk("rstf_ir", 32'(bus.IR), 32'h0000);
      chk("rstf_ir_valid", 32'(bus.ir_valid), 32'd0);
      chk("rstf_mem_req", 32'(bus.mem_req), 32'd0);
      rst = 1'b0;
      step();
      bus.mem_ack = 1'b0;
      chk("rstf_idle_ack_ign", 32'(bus.IR), 32'h0000);
      chk("rstf_issue_req", 32'(bus.mem_req), 32'd0);
      step();
      chk("rstf_fetch_req", 32'(bus.mem_req), 32'd1);
      chk("rstf_fetch_addr", 32'(bus.mem_addr), 32'h9999);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
